mips_data_ram: RTL and testbench

MIPS_DATA_RAM -- requirements
Module: mips_data_ram

---
 rtl/mips_data_ram_pkg.sv | 25 ++
 rtl/mips_ram_array.sv | 30 +++
 rtl/mips_data_ram.sv | 141 ++++++++++++++
 tb/tb_mips_data_ram.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_data_ram_pkg.sv
// Shared types for the MIPS data-side RAM: access FSM states, default geometry
// and the CPU opcode encodings used by the surrounding core.
package mips_data_ram_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } ram_state_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

endpackage

// File: rtl/mips_ram_array.sv
// Word-wide storage with one asynchronous read port and one byte-enabled
// write port; no reset so it maps onto plain RAM.
module mips_ram_array
  import mips_data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_word,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_word,
  input  logic [3:0]    wr_be
);

  logic [31:0] mem_q [DEPTH_WORDS];

  assign rd_word = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mips_data_ram.sv
// Data RAM front end: latches a CPU request, stalls it for WAIT_CYCLES,
// then completes it in a single acceptance cycle with address checking.
module mips_data_ram
  import mips_data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_out,
  input  logic [3:0]  byteenable,
  output logic [31:0] data_in,
  output logic        waitrequest,
  output logic        err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  ram_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          is_wr_q, is_wr_d;
  logic          is_rd_q, is_rd_d;
  logic          bad_q, bad_d;

  logic        req;
  logic [32:0] diff;
  logic        in_range;
  logic        bad_now;
  logic [31:0] rd_word;
  logic        wr_en;
  logic        unused_offset_bits;

  assign req = data_read | data_write;

  // Bit 32 of the widened subtraction is the borrow: address below BASE_ADDR.
  assign diff     = {1'b0, data_address} - {1'b0, BASE_ADDR};
  assign in_range = !diff[32] && ({1'b0, diff[31:0]} < SPAN);
  assign bad_now  = (data_address[1:0] != 2'b00) || !in_range || (data_read && data_write);
  assign unused_offset_bits = ^{diff[32:AW+2], diff[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    is_rd_d = is_rd_q;
    bad_d   = bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = diff[AW+1:2];
          wdata_d = data_out;
          be_d    = byteenable;
          bad_d   = bad_now;
          is_wr_d = data_write & ~data_read;
          is_rd_d = data_read & ~data_write;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (bad_q) err_d = 1'b1;
        is_wr_d = 1'b0;
        is_rd_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      is_wr_q <= 1'b0;
      is_rd_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      is_rd_q <= is_rd_d;
      bad_q   <= bad_d;
    end
  end

  assign wr_en       = !reset && (state_q == S_DONE) && is_wr_q && !bad_q;
  assign waitrequest = !reset && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
  assign data_in     = (!reset && (state_q == S_DONE) && is_rd_q && !bad_q) ? rd_word : 32'h0;
  assign err         = err_q;

  mips_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .rd_idx  (idx_q),
    .rd_word (rd_word),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_word (wdata_q),
    .wr_be   (be_q)
  );

endmodule

// File: tb/tb_mips_data_ram.sv
// Bench for mips_data_ram: directed accesses against a word-array model with
// per-cycle output comparison, plus a WAIT_CYCLES=0 instance for back-to-back reads.
module tb_mips_data_ram;

  localparam int unsigned W1    = 1;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_address, data_out, data_in;
  logic        data_read, data_write, waitrequest, err;
  logic [3:0]  byteenable;

  logic [31:0] addr0, dout0, din0;
  logic        rd0, wr0, wait0, err0;
  logic [3:0]  be0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        chk_en  = 1'b0;
  logic        exp_wait;
  logic [31:0] exp_din;
  logic        exp_err;
  logic        err_m;
  logic [31:0] mem_m [int];
  int          wcnt;
  logic [31:0] last_din;

  always #5 clk = ~clk;

  mips_data_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut (
    .clk          (clk),
    .reset        (rst),
    .data_address (data_address),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_out     (data_out),
    .byteenable   (byteenable),
    .data_in      (data_in),
    .waitrequest  (waitrequest),
    .err          (err)
  );

  mips_data_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .reset        (rst),
    .data_address (addr0),
    .data_read    (rd0),
    .data_write   (wr0),
    .data_out     (dout0),
    .byteenable   (be0),
    .data_in      (din0),
    .waitrequest  (wait0),
    .err          (err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return mem_m.exists(idx) ? mem_m[idx] : 32'hxxxx_xxxx;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_waitrequest", 32'(waitrequest), 32'(exp_wait));
      check("cyc_data_in", data_in, exp_din);
      check("cyc_err", 32'(err), 32'(exp_err));
    end
  end

  // One complete access on the WAIT_CYCLES=1 instance followed by one idle cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    longint unsigned a;
    bit              bad;
    int              idx;
    logic [31:0]     w;
    a   = addr;
    bad = (addr[1:0] != 2'b00) || (a < BASE) || (a >= longint'(BASE) + 4 * DEPTH) || (rd && wr);
    idx = int'((a - BASE) / 4);
    data_read = rd; data_write = wr; data_address = addr; data_out = wdata; byteenable = be;
    wcnt = 0;
    for (int k = 0; k <= W1 + 1; k++) begin
      exp_wait = (k <= W1);
      exp_din  = (k == W1 + 1 && rd && !wr && !bad) ? model_word(idx) : 32'h0;
      exp_err  = err_m;
      chk_en   = 1'b1;
      @(negedge clk);
      if (waitrequest) wcnt++;
      if (k == W1 + 1) last_din = data_in;
      @(posedge clk); #1;
    end
    if (bad) err_m = 1'b1;
    else if (wr) begin
      w = model_word(idx);
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      mem_m[idx] = w;
    end
    data_read = 1'b0; data_write = 1'b0;
    exp_wait = 1'b0; exp_din = 32'h0; exp_err = err_m;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; err_m = 1'b0;
    data_read = 1'b1; data_write = 1'b0; data_address = 32'h10; data_out = 32'h0; byteenable = 4'hF;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; dout0 = 32'h0; be0 = 4'h0;
    #2;
    check("rst_waitrequest", 32'(waitrequest), 32'd0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    data_read = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_access(0, 1, 32'h10, 32'hCAFE_F00D, 4'hF);
    check("wr_10_wait_cycles", 32'(wcnt), 32'd2);
    do_access(1, 0, 32'h10, 32'h0, 4'hF);
    check("rd_10", last_din, 32'hCAFE_F00D);

    do_access(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    do_access(0, 1, 32'h20, 32'h00AB_0000, 4'b0100);
    do_access(1, 0, 32'h20, 32'h0, 4'hF);
    check("rd_20_lanes", last_din, 32'hFFAB_FFFF);

    // Reset during WAIT of a write must not touch storage.
    do_access(0, 1, 32'h30, 32'h0000_0001, 4'hF);
    chk_en = 1'b0;
    data_write = 1'b1; data_address = 32'h30; data_out = 32'hDEAD_BEEF; byteenable = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_waitrequest", 32'(waitrequest), 32'd0);
    check("midrst_data_in", data_in, 32'h0);
    data_write = 1'b0;
    @(negedge clk);
    check("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; err_m = 1'b0;
    @(negedge clk);
    check("postrst_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    do_access(1, 0, 32'h30, 32'h0, 4'hF);
    check("rd_30_after_rst", last_din, 32'h0000_0001);

    // Request withdrawn in WAIT: back to IDLE without committing.
    chk_en = 1'b0;
    data_write = 1'b1; data_address = 32'h30; data_out = 32'h0000_0BAD; byteenable = 4'hF;
    @(negedge clk);
    check("drop_issue_wait", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    data_write = 1'b0;
    @(negedge clk);
    check("drop_in_wait_wait", 32'(waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_idle_wait", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    do_access(1, 0, 32'h30, 32'h0, 4'hF);
    check("rd_30_after_drop", last_din, 32'h0000_0001);

    do_access(1, 1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    check("both_high_err", 32'(err), 32'd1);
    do_access(1, 0, 32'h10, 32'h0, 4'hF);
    check("rd_10_after_both", last_din, 32'hCAFE_F00D);

    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; err_m = 1'b0;
    check("err_cleared", 32'(err), 32'd0);

    do_access(1, 0, 32'h22, 32'h0, 4'hF);
    check("rd_22_data_in", last_din, 32'h0);
    check("rd_22_err", 32'(err), 32'd1);

    do_access(0, 1, 32'hFFC, 32'h5A5A_5A5A, 4'hF);
    do_access(0, 1, BASE + 4 * DEPTH, 32'h0, 4'hF);
    do_access(1, 0, 32'hFFC, 32'h0, 4'hF);
    check("rd_last_word", last_din, 32'h5A5A_5A5A);

    do_access(0, 1, 32'h10, 32'h1234_5678, 4'b0000);
    do_access(1, 0, 32'h10, 32'h0, 4'hF);
    check("rd_10_be0", last_din, 32'hCAFE_F00D);

    // WAIT_CYCLES=0 instance: back-to-back accesses with the request held.
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr0 = 1'b1; addr0 = 32'h100 + 32'(4 * i); dout0 = 32'h1111_0000 + 32'(i); be0 = 4'hF;
      @(negedge clk);
      check("w0_issue_wait", 32'(wait0), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("w0_done_wait", 32'(wait0), 32'd0);
      @(posedge clk); #1;
    end
    wr0 = 1'b0; rd0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr0 = 32'h100 + 32'(4 * i);
      @(negedge clk);
      check("r0_issue_wait", 32'(wait0), 32'd1);
      check("r0_issue_din", din0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("r0_done_wait", 32'(wait0), 32'd0);
      check("r0_done_din", din0, 32'h1111_0000 + 32'(i));
      @(posedge clk); #1;
    end
    rd0 = 1'b0;
    @(negedge clk);
    check("r0_idle_wait", 32'(wait0), 32'd0);
    check("r0_err", 32'(err0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
